vector3_byte_serializer: RTL and testbench

//   Downstream stage of the Vector3 field packer. Accepts one 32-bit frame as

---
 rtl/vector3_byte_serializer.sv | 116 +++++++++++
 tb/tb_vector3_byte_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vector3_byte_serializer.sv
// Vector3 frame serializer: takes a 4-byte frame {w,x,y,z} and emits it one byte per
// valid/ready handshake, w first; frames whose z[1:0] sync marker is not 2'b11 are dropped and counted.
module vector3_byte_serializer #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           w,
   input  logic [7:0]           x,
   input  logic [7:0]           y,
   input  logic [7:0]           z,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [7:0]           out_data,
   output logic [1:0]           out_idx,
   output logic                 out_last,
   output logic                 sync_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            frame_q, frame_d;
   logic                   out_valid_q, out_valid_d;
   logic [7:0]             out_data_q, out_data_d;
   logic [1:0]             out_idx_q, out_idx_d;
   logic                   sync_err_q, sync_err_d;
   logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

   logic accept, good_marker, out_hs, last_hs;
   logic [1:0] idx_nxt;
   logic [7:0] byte_nxt;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_valid_q & (out_idx_q == 2'd3);
   assign sync_err  = sync_err_q;
   assign err_count = err_count_q;

   assign out_hs      = out_valid_q & out_ready;
   assign last_hs     = out_hs & out_last;
   // Accepting on the last-byte handshake lets frames run back to back.
   assign in_ready    = (state_q == IDLE) | last_hs;
   assign accept      = in_valid & in_ready;
   assign good_marker = (z[1:0] == 2'b11);
   assign idx_nxt     = out_idx_q + 2'd1;

   always_comb begin
      byte_nxt = frame_q[31:24];
      case (idx_nxt)
         2'd0: byte_nxt = frame_q[31:24];
         2'd1: byte_nxt = frame_q[23:16];
         2'd2: byte_nxt = frame_q[15:8];
         2'd3: byte_nxt = frame_q[7:0];
         default: byte_nxt = frame_q[31:24];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      sync_err_d  = 1'b0;
      err_count_d = err_count_q;

      if (accept && good_marker) begin
         state_d     = SEND;
         frame_d     = {w, x, y, z};
         out_valid_d = 1'b1;
         out_idx_d   = 2'd0;
         out_data_d  = w;
      end else if (accept) begin
         // Bad marker: drop the frame; any held frame has just finished.
         state_d     = IDLE;
         out_valid_d = 1'b0;
         out_idx_d   = 2'd0;
         sync_err_d  = 1'b1;
         if (err_count_q != '1)
            err_count_d = err_count_q + 1'b1;
      end else if (last_hs) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         out_idx_d   = 2'd0;
      end else if (out_hs) begin
         out_idx_d  = idx_nxt;
         out_data_d = byte_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         sync_err_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         sync_err_q  <= sync_err_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_vector3_byte_serializer.sv
// Bench for vector3_byte_serializer: two instances (8-bit and 2-bit error counter) share stimulus
// and are compared every cycle against a queue-based reference model of the byte stream.
module tb_vector3_byte_serializer;

   logic       clk, rst_n;
   logic       in_valid, out_ready;
   logic [7:0] w, x, y, z;

   logic       in_ready_a, out_valid_a, out_last_a, sync_err_a;
   logic [7:0] out_data_a, err_count_a;
   logic [1:0] out_idx_a;
   logic       in_ready_b, out_valid_b, out_last_b, sync_err_b;
   logic [7:0] out_data_b;
   logic [1:0] out_idx_b, err_count_b;

   vector3_byte_serializer #(.ERR_CNT_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .w(w), .x(x), .y(y), .z(z), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a),
      .sync_err(sync_err_a), .err_count(err_count_a));

   vector3_byte_serializer #(.ERR_CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .w(w), .x(x), .y(y), .z(z), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b),
      .sync_err(sync_err_b), .err_count(err_count_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] idx;
      logic [7:0] data;
   } ent_t;

   ent_t pend[$];
   int   errs;
   bit   m_sync;
   int   n_tests, n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_outputs(input bit ordy);
      bit   exp_v, exp_ir;
      exp_v  = (pend.size() != 0);
      exp_ir = (pend.size() == 0) || (pend.size() == 1 && ordy);
      chk("in_ready8", in_ready_a, exp_ir);
      chk("in_ready2", in_ready_b, exp_ir);
      chk("out_valid8", out_valid_a, exp_v);
      chk("out_valid2", out_valid_b, exp_v);
      if (exp_v) begin
         chk("out_data8", out_data_a, pend[0].data);
         chk("out_data2", out_data_b, pend[0].data);
         chk("out_idx8", out_idx_a, pend[0].idx);
         chk("out_idx2", out_idx_b, pend[0].idx);
      end
      chk("out_last8", out_last_a, exp_v && pend[0].idx == 2'd3);
      chk("out_last2", out_last_b, exp_v && pend[0].idx == 2'd3);
      chk("sync_err8", sync_err_a, m_sync);
      chk("sync_err2", sync_err_b, m_sync);
      chk("err_count8", err_count_a, sat(errs, 255));
      chk("err_count2", err_count_b, sat(errs, 3));
   endtask

   // Called at a negedge: drive, check, then advance the model across the posedge.
   task automatic step(input bit iv, input logic [7:0] a, b, c, d, input bit ordy);
      bit hs, acc;
      in_valid  = iv;
      w = a; x = b; y = c; z = d;
      out_ready = ordy;
      #1;
      check_outputs(ordy);
      hs  = (pend.size() != 0) && ordy;
      acc = iv && ((pend.size() == 0) || (pend.size() == 1 && ordy));
      @(posedge clk);
      if (hs) void'(pend.pop_front());
      m_sync = 1'b0;
      if (acc) begin
         if (d[1:0] == 2'b11) begin
            pend.push_back('{2'd0, a});
            pend.push_back('{2'd1, b});
            pend.push_back('{2'd2, c});
            pend.push_back('{2'd3, d});
         end else begin
            errs++;
            m_sync = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, ordy);
   endtask

   initial begin
      bit pat[4];
      logic [7:0] rz;
      n_tests = 0; n_fail = 0; errs = 0; m_sync = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; w = '0; x = '0; y = '0; z = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_data", out_data_a, 0);
      chk("rst_out_idx", out_idx_a, 0);
      chk("rst_sync_err", sync_err_a, 0);
      chk("rst_err_count", err_count_a, 0);
      chk("rst_in_ready", in_ready_a, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single frame, sink always ready
      step(1'b1, 8'hA1, 8'hB2, 8'hC3, 8'hD7, 1'b1);
      idle(5, 1'b1);

      // 2: same frame under 1,0,0,1 backpressure
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      step(1'b1, 8'hA1, 8'hB2, 8'hC3, 8'hD7, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, pat[i % 4]);

      // 3: back-to-back frames with in_valid held high
      step(1'b1, 8'h11, 8'h22, 8'h33, 8'h47, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h55, 8'h66, 8'h77, 8'h8B, 1'b1);
      idle(5, 1'b1);

      // 4: bad marker then good frame
      step(1'b1, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1);
      idle(1, 1'b1);
      step(1'b1, 8'h01, 8'h02, 8'h03, 8'h07, 1'b1);
      idle(5, 1'b1);

      // 6: reset mid-frame after two bytes
      step(1'b1, 8'hA1, 8'hB2, 8'hC3, 8'hD7, 1'b1);
      idle(2, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid_a, 0);
      chk("midrst_err_count", err_count_a, 0);
      chk("midrst_out_idx", out_idx_a, 0);
      chk("midrst_in_ready", in_ready_a, 1);
      pend.delete(); errs = 0; m_sync = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'hE1, 8'hE2, 8'hE3, 8'hEF, 1'b1);
      idle(5, 1'b1);

      // 5: five bad frames, saturation of the 2-bit counter
      for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00 | 8'(i % 3), 1'b1);
      idle(2, 1'b1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rz = 8'($urandom);
         if ($urandom_range(0, 3) != 0) rz[1:0] = 2'b11;
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), rz,
              $urandom_range(0, 3) != 0);
      end
      idle(6, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
